// File: rtl/fifo_burst_reader.sv
`timescale 1ns/1ps
// fifo_burst_reader
// Drains an upstream show-ahead FIFO in bursts. A full burst of BURST_LEN words
// starts as soon as enough words are present. If fewer are present, a partial
// burst is flushed after the FIFO has been non-empty for TIMEOUT cycles.
// Output words come straight from the FIFO head, with no added latency.
//
// Ports:
//   clk, rst      sole clock, synchronous active-high reset
//   fifo_rdempty  upstream FIFO empty
//   fifo_rdusedw  upstream FIFO occupancy
//   fifo_q        upstream FIFO head word
//   fifo_rdreq    pop the head word (an accepted output beat)
//   out_valid, out_ready, out_data
//                 downstream valid/ready word stream
//   out_sop       first word of a burst
//   out_eop       last word of a burst
//   out_len       word count of the current burst
//   burst_count   number of completed bursts (wraps)
module fifo_burst_reader #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 10,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_rdempty,
  input  logic [LOG_DEPTH:0]   fifo_rdusedw,
  input  logic [WIDTH-1:0]     fifo_q,
  output logic                 fifo_rdreq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [LOG_DEPTH:0]   out_len,
  output logic [31:0]          burst_count
);

  localparam int CW = LOG_DEPTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] BLEN  = CW'(BURST_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] remaining;
  logic [CW-1:0] len_r;

  logic full_rdy;
  logic tmo_rdy;

  assign full_rdy = (fifo_rdusedw >= BLEN);
  // A lagging usedw of 0 holds off the flush, so a burst length is never 0.
  assign tmo_rdy  = !fifo_rdempty && (timer == TLAST) && (fifo_rdusedw != '0);

  // The output is qualified by !rst so that no word is popped on the reset edge.
  // Any unread words then stay in the FIFO for a later burst.
  assign out_valid  = (state == BURST) && !fifo_rdempty && !rst;
  assign fifo_rdreq = out_valid && out_ready;
  assign out_data   = fifo_q;
  assign out_sop    = out_valid && (remaining == len_r);
  assign out_eop    = out_valid && (remaining == CW'(1));
  assign out_len    = len_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      remaining   <= '0;
      len_r       <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full_rdy) begin
            state     <= BURST;
            len_r     <= BLEN;
            remaining <= BLEN;
            timer     <= '0;
          end else if (tmo_rdy) begin
            // The full-burst branch has lost, so usedw < BURST_LEN here and
            // min(usedw, BURST_LEN) is simply usedw.
            state     <= BURST;
            len_r     <= fifo_rdusedw;
            remaining <= fifo_rdusedw;
            timer     <= '0;
          end else if (fifo_rdempty) begin
            timer <= '0;
          end else if (timer != TLAST) begin
            // The timer saturates while a lagging usedw defers the flush.
            timer <= timer + 1'b1;
          end
        end
        BURST: begin
          if (fifo_rdreq) begin
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
              state       <= IDLE;
              burst_count <= burst_count + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  localparam int W  = 16;
  localparam int LD = 4;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rdempty;
  logic [LD:0]   fifo_rdusedw;
  logic [W-1:0]  fifo_q;
  logic          fifo_rdreq;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_sop;
  logic          out_eop;
  logic [LD:0]   out_len;
  logic [31:0]   burst_count;

  int nvec = 0;
  int nmis = 0;

  // Show-ahead FIFO model. Words pushed by the stimulus land at the next posedge.
  logic [W-1:0] pend[$];
  logic [W-1:0] mem[$];
  logic [LD:0]  cnt   = '0;
  logic [W-1:0] head  = '0;
  logic         stall = 1'b0;
  logic [W-1:0] wr_next = 16'h0100;
  logic [W-1:0] rd_next = 16'h0100;
  logic [31:0]  exp_bc  = '0;

  assign fifo_rdempty = (cnt == '0) || stall;
  assign fifo_rdusedw = cnt;
  assign fifo_q       = head;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rdreq && mem.size() > 0) void'(mem.pop_front());
    while (pend.size() > 0) mem.push_back(pend.pop_front());
    cnt  <= (LD+1)'(mem.size());
    head <= (mem.size() > 0) ? mem[0] : '0;
  end

  fifo_burst_reader #(.WIDTH(W), .LOG_DEPTH(LD), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
    .burst_count(burst_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      pend.push_back(wr_next);
      wr_next = wr_next + 1'b1;
    end
  endtask

  // Waits for a burst, then drives the ready/stall patterns cycle by cycle and
  // checks every beat against the expected in-order stream.
  task automatic run_burst(input string tag, input int n, input logic [15:0] rpat,
                           input logic [15:0] spat, input int exp_wait);
    int   to  = 0;
    int   acc = 0;
    int   k   = 0;
    logic r, v;
    out_ready = 1'b1;
    stall     = 1'b0;
    #1;
    while (!out_valid && to < 60) begin
      @(negedge clk); #1;
      to++;
    end
    if (exp_wait >= 0) chk({tag, ".lat"}, to, exp_wait);
    else               chk({tag, ".start"}, out_valid, 1);
    while (acc < n && k < 40) begin
      r = (k < 16) ? rpat[k] : 1'b1;
      v = (k < 16) ? !spat[k] : 1'b1;
      out_ready = r;
      stall     = !v;
      #1;
      chk({tag, ".valid"}, out_valid, v);
      if (v) begin
        chk({tag, ".data"}, out_data, rd_next);
        chk({tag, ".sop"},  out_sop,  acc == 0);
        chk({tag, ".eop"},  out_eop,  acc == n - 1);
        chk({tag, ".len"},  out_len,  n);
      end
      chk({tag, ".rdreq"}, fifo_rdreq, v && r);
      if (v && r) begin
        acc++;
        rd_next = rd_next + 1'b1;
      end
      k++;
      @(negedge clk);
    end
    chk({tag, ".beats"}, acc, n);
    out_ready = 1'b1;
    stall     = 1'b0;
    #1;
    exp_bc = exp_bc + 1;
    chk({tag, ".idle"}, out_valid, 0);
    chk({tag, ".bcnt"}, burst_count, exp_bc);
  endtask

  initial begin
    int to;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.rdreq", fifo_rdreq, 0);
    chk("rst.sop",   out_sop, 0);
    chk("rst.eop",   out_eop, 0);
    chk("rst.len",   out_len, 0);
    chk("rst.bcnt",  burst_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full burst: the decision takes one cycle, then four back-to-back beats
    push(4);
    run_burst("full", 4, 16'hFFFF, 16'h0000, 2);
    repeat (3) @(negedge clk);

    // Partial burst flushed by the timeout
    push(2);
    run_burst("tmo2", 2, 16'hFFFF, 16'h0000, 9);
    repeat (3) @(negedge clk);

    // Nine words: two full bursts, then a single-word timeout burst
    push(9);
    run_burst("b9a", 4, 16'hFFFF, 16'h0000, -1);
    run_burst("b9b", 4, 16'hFFFF, 16'h0000, -1);
    run_burst("b9c", 1, 16'hFFFF, 16'h0000, -1);
    repeat (3) @(negedge clk);

    // Backpressure with ready pattern 1,0,0,1,...
    push(4);
    run_burst("bp", 4, 16'hFFF9, 16'h0000, -1);
    repeat (3) @(negedge clk);

    // FIFO goes empty for three cycles mid-burst
    push(4);
    run_burst("stall", 4, 16'hFFFF, 16'h000E, -1);
    repeat (3) @(negedge clk);

    // Reset after two beats: the rest is emitted later as a timeout burst
    push(4);
    out_ready = 1'b1;
    to = 0;
    #1;
    while (!out_valid && to < 60) begin
      @(negedge clk); #1;
      to++;
    end
    chk("rstmid.start", out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      chk("rstmid.data", out_data, rd_next);
      chk("rstmid.sop",  out_sop, i == 0);
      rd_next = rd_next + 1'b1;
      @(negedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rstmid.valid0", out_valid, 0);
    chk("rstmid.rdreq0", fifo_rdreq, 0);
    @(negedge clk); #1;
    chk("rstmid.valid1", out_valid, 0);
    chk("rstmid.eop",    out_eop, 0);
    chk("rstmid.bcnt",   burst_count, 0);
    chk("rstmid.len",    out_len, 0);
    rst    = 1'b0;
    exp_bc = '0;
    run_burst("rsttail", 2, 16'hFFFF, 16'h0000, -1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
